// File: rtl/inside_grid_scan.sv
// Grid scanner: walks a rectangular point grid against one latched jammer and
// accumulates the hit count and bounding box of points inside the jammer radius.

module inside_ #(
    parameter int N = 8
) (
    input  logic signed [N+1:0] xp,
    input  logic signed [N+1:0] yp,
    input  logic signed [N-1:0] xj,
    input  logic signed [N-1:0] yj,
    input  logic        [N:0]   rj,
    output logic                in_range
);
    localparam int DW = N + 3;
    localparam int SW = 2 * N + 6;

    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic signed [SW-1:0] dx_ext;
    logic signed [SW-1:0] dy_ext;
    logic signed [SW-1:0] sq_x;
    logic signed [SW-1:0] sq_y;
    logic        [SW-1:0] dist2;
    logic        [SW-1:0] r_ext;
    logic        [SW-1:0] r2;

    // Operands are widened before the subtract so the extreme corner of the grid
    // against the opposite jammer extreme cannot overflow.
    always_comb begin
        dx     = $signed({xp[N+1], xp}) - $signed({{3{xj[N-1]}}, xj});
        dy     = $signed({yp[N+1], yp}) - $signed({{3{yj[N-1]}}, yj});
        dx_ext = $signed({{(SW-DW){dx[DW-1]}}, dx});
        dy_ext = $signed({{(SW-DW){dy[DW-1]}}, dy});
        sq_x   = dx_ext * dx_ext;
        sq_y   = dy_ext * dy_ext;
        dist2  = $unsigned(sq_x + sq_y);
        r_ext  = {{(SW-N-1){1'b0}}, rj};
        r2     = r_ext * r_ext;
        in_range = (dist2 <= r2);
    end
endmodule

module inside_grid_scan #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [N+1:0]  x_min,
    input  logic signed [N+1:0]  x_max,
    input  logic signed [N+1:0]  y_min,
    input  logic signed [N+1:0]  y_max,
    input  logic        [N-1:0]  step,
    input  logic signed [N-1:0]  xJ,
    input  logic signed [N-1:0]  yJ,
    input  logic        [N:0]    rJ,
    output logic                 busy,
    output logic                 done,
    output logic        [2*N+4:0] hit_count,
    output logic                 any_hit,
    output logic signed [N+1:0]  bb_xmin,
    output logic signed [N+1:0]  bb_xmax,
    output logic signed [N+1:0]  bb_ymin,
    output logic signed [N+1:0]  bb_ymax
);
    localparam int PW = N + 2;
    localparam int EW = N + 3;
    localparam int CW = 2 * N + 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic signed [PW-1:0] x_min_q;
    logic signed [PW-1:0] x_max_q;
    logic signed [PW-1:0] y_max_q;
    logic        [N-1:0]  step_q;
    logic signed [N-1:0]  xj_q;
    logic signed [N-1:0]  yj_q;
    logic        [N:0]    rj_q;
    logic signed [PW-1:0] xp;
    logic signed [PW-1:0] yp;

    logic signed [EW-1:0] x_nx;
    logic signed [EW-1:0] y_nx;
    logic                 x_adv;
    logic                 y_adv;
    logic                 last_pt;
    logic                 empty_grid;
    logic                 accept;
    logic                 hit;
    logic                 hit_en;

    function automatic logic signed [PW-1:0] smin(input logic signed [PW-1:0] a,
                                                  input logic signed [PW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [PW-1:0] smax(input logic signed [PW-1:0] a,
                                                  input logic signed [PW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Advance arithmetic is one bit wider than the coordinates so a point near
    // the positive limit plus a large pitch compares correctly instead of wrapping.
    always_comb begin
        x_nx       = $signed({xp[PW-1], xp}) + $signed({3'b000, step_q});
        y_nx       = $signed({yp[PW-1], yp}) + $signed({3'b000, step_q});
        x_adv      = (x_nx <= $signed({x_max_q[PW-1], x_max_q}));
        y_adv      = (y_nx <= $signed({y_max_q[PW-1], y_max_q}));
        last_pt    = !x_adv && !y_adv;
        empty_grid = (x_max < x_min) || (y_max < y_min);
        accept     = (state == S_IDLE) && start;
        hit_en     = (state == S_SCAN) && hit;
    end

    inside_ #(.N(N)) u_inside (
        .xp       (xp),
        .yp       (yp),
        .xj       (xj_q),
        .yj       (yj_q),
        .rj       (rj_q),
        .in_range (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = empty_grid ? S_FIN : S_SCAN;
                end
            end
            S_SCAN: begin
                if (last_pt) begin
                    state_nx = S_FIN;
                end
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state == S_SCAN);
    assign done = (state == S_FIN);

    // Scan operands and the point walker carry no reset: they are only
    // consumed while scanning, which always starts from a fresh latch.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_min_q <= x_min;
            x_max_q <= x_max;
            y_max_q <= y_max;
            step_q  <= (step == '0) ? N'(1) : step;
            xj_q    <= xJ;
            yj_q    <= yJ;
            rj_q    <= rJ;
            xp      <= x_min;
            yp      <= y_min;
        end else if (state == S_SCAN) begin
            if (x_adv) begin
                xp <= x_nx[PW-1:0];
            end else if (y_adv) begin
                xp <= x_min_q;
                yp <= y_nx[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count <= '0;
            any_hit   <= 1'b0;
            bb_xmin   <= '0;
            bb_xmax   <= '0;
            bb_ymin   <= '0;
            bb_ymax   <= '0;
        end else if (accept) begin
            hit_count <= '0;
            any_hit   <= 1'b0;
            bb_xmin   <= '0;
            bb_xmax   <= '0;
            bb_ymin   <= '0;
            bb_ymax   <= '0;
        end else if (hit_en) begin
            hit_count <= hit_count + CW'(1);
            any_hit   <= 1'b1;
            if (!any_hit) begin
                bb_xmin <= xp;
                bb_xmax <= xp;
                bb_ymin <= yp;
                bb_ymax <= yp;
            end else begin
                bb_xmin <= smin(bb_xmin, xp);
                bb_xmax <= smax(bb_xmax, xp);
                bb_ymin <= smin(bb_ymin, yp);
                bb_ymax <= smax(bb_ymax, yp);
            end
        end
    end
endmodule

// File: doc/inside_grid_scan.md
Name: inside_grid_scan

Overview:
- Sequential feeder and consumer for the combinational `inside_` range check.
- Latches one jammer (xJ, yJ, rJ) and walks a rectangular grid of candidate points P in row-major order, one point per clock.
- Each point goes to an internal `inside_` instance (parameter N). The block accumulates the hit count and the bounding box of in-range points.
- Sits between the localization controller and the per-jammer range logic; the controller later intersects the results across jammers.

Parameters:
- N, 8, coordinate base width: jammer x/y are N-bit signed, rJ is N+1-bit unsigned, point x/y are N+2-bit signed.

Ports:
- clk  input  1  single clock; all registers rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- x_min  input  N+2  signed grid lower x bound, inclusive.
- x_max  input  N+2  signed grid upper x bound, inclusive.
- y_min  input  N+2  signed grid lower y bound, inclusive.
- y_max  input  N+2  signed grid upper y bound, inclusive.
- step  input  N  unsigned grid pitch; 0 is treated as 1.
- xJ  input  N  signed jammer x.
- yJ  input  N  signed jammer y.
- rJ  input  N+1  unsigned jammer radius.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when a scan completes.
- hit_count  output  2N+5  number of grid points with in_range=1.
- any_hit  output  1  at least one hit in the last scan.
- bb_xmin  output  N+2  signed bounding box of hits; valid when any_hit=1.
- bb_xmax  output  N+2  signed bounding box of hits; valid when any_hit=1.
- bb_ymin  output  N+2  signed bounding box of hits; valid when any_hit=1.
- bb_ymax  output  N+2  signed bounding box of hits; valid when any_hit=1.

Behaviour:
- Reset:
  - Synchronous, active-high, takes priority over everything.
  - State goes to IDLE; busy=0, done=0, hit_count=0, any_hit=0, all bb_* = 0.
  - Reset mid-scan aborts the scan with no done pulse.
- States: IDLE, SCAN, FIN.
- IDLE:
  - On start=1, latch all bound, step and jammer inputs.
  - Clear hit_count, any_hit and bb_*.
  - Set xP=x_min, yP=y_min.
  - If x_max<x_min or y_max<y_min (signed compare): go to FIN with count 0.
  - Otherwise go to SCAN with busy=1 from the next cycle.
- SCAN, each cycle:
  - Evaluate the current (xP, yP) through `inside_`. Hit means (xP-xJ)²+(yP-yJ)² ≤ rJ².
  - On a hit: increment hit_count and set any_hit.
  - On the first hit: load all four bb_* from xP/yP.
  - On later hits: update bb_* with signed min/max.
- SCAN, advance:
  - Compute xP+step and yP+step in N+3-bit signed, so there is no wrap at the coordinate maximum.
  - If xP+step ≤ x_max: xP advances.
  - Else if yP+step ≤ y_max: xP returns to x_min and yP advances.
  - Else the current point is the last one; go to FIN.
- FIN:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency and throughput:
  - One point per cycle.
  - A scan of K points holds busy for K cycles; done follows the last point by one cycle.
  - Degenerate scans: busy stays 0 and done pulses the cycle after start.
- Result outputs:
  - Hold their value from FIN until the next accepted start.
  - Are registered and change only on clock edges.
- start while busy or in FIN is ignored; no queuing.
- Input changes during SCAN do not affect the scan, since all inputs are latched.
- hit_count width 2N+5 covers the full (2^(N+2))² grid without saturation.

Test Plan:
- N=8, J=(0,0), rJ=3, grid x,y −5..5, step 1 → busy for 121 cycles, done pulse at cycle 122; hit_count=29, any_hit=1, bb = (−3,3,−3,3).
- x_min=4, x_max=2 with start → no busy; done the next cycle; hit_count=0, any_hit=0.
- J=(2,2), rJ=0, grid 0..4, step 2 → 9 points, busy 9 cycles; hit_count=1, bb all = 2.
- x_min=x_max=511, y −2..2, step 255, J=(127,0), rJ=255 → no coordinate wrap; 1 column of points y ∈ {−2} → hit_count matches the golden model. step=0 with a 3×3 grid → behaves as step 1, 9 points.
- Reset asserted at scan cycle 50 of the first scenario → next cycle busy=0, hit_count=0, no done pulse. A fresh start then reproduces 29.
- start pulsed on cycle 10 of an active scan → ignored; results identical to the uninterrupted run.
